// File: rtl/i2s_tx_sequencer.sv
// Frame scheduler for i2s_transmitter: arbitrates two stereo requesters into a one-pair
// hold buffer and sequences LEFT/RIGHT slots. Optional macro ARB_RR_EN selects round-robin.
module i2s_tx_sequencer #(
  parameter int SAMPLE_W  = 12,
  parameter int SLOT_BITS = 16
) (
  input  logic                s_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] silence,
  input  logic                req0_valid,
  input  logic [SAMPLE_W-1:0] req0_left,
  input  logic [SAMPLE_W-1:0] req0_right,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [SAMPLE_W-1:0] req1_left,
  input  logic [SAMPLE_W-1:0] req1_right,
  output logic                req1_ready,
  output logic [SAMPLE_W-1:0] tx_sound_in,
  output logic                tx_load,
  output logic                word_select,
  output logic                underrun,
  output logic                active
);
  localparam int CW = $clog2(SLOT_BITS);
  localparam logic [CW-1:0] LAST = CW'(SLOT_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  logic [1:0]          state;
  logic [CW-1:0]       bit_cnt;
  logic                hold_full;
  logic [SAMPLE_W-1:0] hold_l, hold_r, cur_l, cur_r;
  logic                open, grant0, grant1;
  logic                slot_end, frame_start, right_start, go_idle;

  // Accepts are blocked while in reset so no pair is silently swallowed.
  assign open = enable && !hold_full && !reset;

`ifdef ARB_RR_EN
  logic last_grant;
  assign grant0 = open && req0_valid && (!req1_valid || last_grant);
  assign grant1 = open && req1_valid && (!req0_valid || !last_grant);
`else
  assign grant0 = open && req0_valid;
  assign grant1 = open && req1_valid && !req0_valid;
`endif

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign active      = (state != IDLE);

  assign slot_end    = (bit_cnt == LAST);
  assign frame_start = enable && ((state == IDLE) || (state == RIGHT && slot_end));
  assign right_start = (state == LEFT) && slot_end;
  assign go_idle     = !enable && ((state == IDLE) || (state == RIGHT && slot_end));

  always_ff @(posedge s_clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      hold_full   <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      cur_l       <= '0;
      cur_r       <= '0;
      tx_sound_in <= '0;
      tx_load     <= 1'b0;
      word_select <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      tx_load  <= 1'b0;
      underrun <= 1'b0;
      if (frame_start) begin
        state       <= LEFT;
        bit_cnt     <= '0;
        tx_load     <= 1'b1;
        word_select <= 1'b0;
        // Frame content is frozen here; a pair accepted this same cycle waits a frame.
        if (hold_full) begin
          cur_l       <= hold_l;
          cur_r       <= hold_r;
          tx_sound_in <= hold_l;
          hold_full   <= 1'b0;
        end else begin
          cur_l       <= silence;
          cur_r       <= silence;
          tx_sound_in <= silence;
          underrun    <= 1'b1;
        end
      end else if (right_start) begin
        state       <= RIGHT;
        bit_cnt     <= '0;
        tx_load     <= 1'b1;
        word_select <= 1'b1;
        tx_sound_in <= cur_r;
      end else if (go_idle) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        word_select <= 1'b0;
        tx_sound_in <= silence;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end

      // Grants require an empty hold, so they never collide with the consume above.
      if (grant0) begin
        hold_l    <= req0_left;
        hold_r    <= req0_right;
        hold_full <= 1'b1;
      end else if (grant1) begin
        hold_l    <= req1_left;
        hold_r    <= req1_right;
        hold_full <= 1'b1;
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge s_clk) begin
    if (reset)       last_grant <= 1'b1;
    else if (grant0) last_grant <= 1'b0;
    else if (grant1) last_grant <= 1'b1;
  end
`endif

endmodule
